// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier datapath: FSM encoding,
// accumulator sizing and the partial-product digit convention.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Digit i has value sext(gen) + sign and weight 4^i, so it shifts by 2*i bits.
  localparam int DIGIT_BITS = 2;

  // Product width: the multiplicand plus two bits per digit, plus one sign bit of headroom.
  function automatic int acc_w(input int width, input int npp);
    return width + DIGIT_BITS * npp + 1;
  endfunction

endpackage

// File: rtl/booth_pp_align.sv
// Turns one Booth digit (gen, sign) at index idx into its AW-bit addend at weight 4^idx.
module booth_pp_align
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NPP   = 5,
  localparam int AW   = acc_w(WIDTH, NPP),
  localparam int IW   = $clog2(NPP)
) (
  input  logic [WIDTH:0]  pp_gen,
  input  logic            pp_sign,
  input  logic [IW-1:0]   idx,
  output logic [AW-1:0]   addend
);

  logic [AW-1:0] gen_x;
  logic [AW-1:0] sgn_x;
  int            shamt;

  always_comb begin
    gen_x  = {{(AW-WIDTH-1){pp_gen[WIDTH]}}, pp_gen};
    sgn_x  = {{(AW-1){1'b0}}, pp_sign};
    shamt  = DIGIT_BITS * int'(idx);
    // Both terms land in one adder; the sign bit is the two's complement +1 of a negated digit.
    addend = (gen_x << shamt) + (sgn_x << shamt);
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Iterative Booth partial-product accumulator: one digit per handshake, LSB digit
// first, product presented on a valid/ready port after NPP digits.
module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NPP   = 5,
  localparam int AW   = acc_w(WIDTH, NPP),
  localparam int IW   = $clog2(NPP)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           abort,
  input  logic           pp_valid,
  output logic           pp_ready,
  input  logic [WIDTH:0] pp_gen,
  input  logic           pp_sign,
  output logic           prod_valid,
  input  logic           prod_ready,
  output logic [AW-1:0]  prod,
  output logic           busy
);

  localparam logic [IW-1:0] LAST = IW'(NPP - 1);

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [AW-1:0] acc, acc_n;
  logic [AW-1:0] addend;
  logic          pp_hs, prod_hs;

  // idx is held at 0 outside ACCUM, so the aligner yields addend(0) in IDLE and DONE.
  booth_pp_align #(.WIDTH(WIDTH), .NPP(NPP)) u_align (
    .pp_gen  (pp_gen),
    .pp_sign (pp_sign),
    .idx     (idx),
    .addend  (addend)
  );

  always_comb begin
    pp_ready   = (state == DONE) ? prod_ready : 1'b1;
    prod_valid = (state == DONE);
    busy       = (state != IDLE);
    prod       = acc;
    pp_hs      = pp_valid && pp_ready;
    prod_hs    = prod_valid && prod_ready;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    acc_n   = acc;
    if (abort) begin
      state_n = IDLE;
      idx_n   = '0;
      acc_n   = '0;
    end else begin
      case (state)
        IDLE: if (pp_hs) begin
          acc_n   = addend;
          idx_n   = IW'(1);
          state_n = ACCUM;
        end
        ACCUM: if (pp_hs) begin
          acc_n = acc + addend;
          if (idx == LAST) begin
            idx_n   = '0;
            state_n = DONE;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
        DONE: if (prod_hs && pp_hs) begin
          acc_n   = addend;
          idx_n   = IW'(1);
          state_n = ACCUM;
        end else if (prod_hs) begin
          idx_n   = '0;
          state_n = IDLE;
        end
        default: begin
          idx_n   = '0;
          acc_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      acc   <= acc_n;
    end
  end

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Randomized and directed bench for booth_pp_accumulator (WIDTH=8, NPP=5, AW=19).
module tb_booth_pp_accumulator;

  localparam int WIDTH = 8;
  localparam int NPP   = 5;
  localparam int AW    = 19;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          abort = 0;
  logic          pp_valid = 0;
  logic          pp_ready;
  logic [WIDTH:0] pp_gen = '0;
  logic          pp_sign = 0;
  logic          prod_valid;
  logic          prod_ready = 0;
  logic [AW-1:0] prod;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH:0] g [NPP];
  logic           s [NPP];

  always #5 clk = ~clk;

  booth_pp_accumulator #(.WIDTH(WIDTH), .NPP(NPP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort      (abort),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .pp_gen     (pp_gen),
    .pp_sign    (pp_sign),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod),
    .busy       (busy)
  );

  // Reference: sum of (signed gen + sign) * 4^i, reduced mod 2^AW.
  function automatic logic [AW-1:0] model(input logic [WIDTH:0] gg [NPP], input logic ss [NPP]);
    longint sum = 0;
    for (int i = 0; i < NPP; i++) begin
      int v = $signed(gg[i]);
      sum += (longint'(v) + longint'(ss[i])) * (longint'(1) << (2 * i));
    end
    return sum[AW-1:0];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NPP; i++) begin
      g[i] = 9'($urandom_range(0, 511));
      s[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Offer one digit after `gap` idle cycles; returns at the negedge after its handshake.
  task automatic send(input logic [WIDTH:0] gen, input logic sgn, input int gap);
    int t = 0;
    repeat (gap) begin
      pp_valid = 0;
      pp_gen   = 9'($urandom);
      pp_sign  = 1'($urandom);
      @(negedge clk);
    end
    pp_valid = 1;
    pp_gen   = gen;
    pp_sign  = sgn;
    while (!pp_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!pp_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: pp_ready=%b required 1", pp_ready);
    end
    @(posedge clk);
    @(negedge clk);
    pp_valid = 0;
  endtask

  task automatic send_all(input int maxgap);
    for (int i = 0; i < NPP; i++) send(g[i], s[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic drain();
    prod_ready = 1;
    @(posedge clk);
    @(negedge clk);
    prod_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    n_cmp++;
    if (pp_ready !== 1'b1 || prod_valid !== 1'b0 || busy !== 1'b0 || prod !== '0) begin
      n_bad++;
      $display("FAIL reset: ready=%b valid=%b busy=%b prod=%h required 1 0 0 00000",
               pp_ready, prod_valid, busy, prod);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [AW-1:0] exp_tab [4];
    exp_tab[0] = 19'h00000;
    exp_tab[1] = 19'h7FFFF;
    exp_tab[2] = 19'h153AB;
    exp_tab[3] = 19'h6AB00;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NPP; i++) begin
        s[i] = 0;
        case (c)
          0: g[i] = 9'h000;
          1: g[i] = (i == 0) ? 9'h003 : (i == 1) ? 9'h1FE : 9'h000;
          2: g[i] = 9'h0FF;
          default: g[i] = 9'h100;
        endcase
      end
      if (c == 1) s[1] = 1;
      prod_ready = 0;
      for (int i = 0; i < NPP - 1; i++) send(g[i], s[i], 0);
      n_cmp++;
      if (prod_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL early_valid case%0d: prod_valid=%b required 0", c, prod_valid);
      end
      send(g[NPP-1], s[NPP-1], 0);
      n_cmp++;
      if (prod_valid !== 1'b1 || prod !== exp_tab[c]) begin
        n_bad++;
        $display("FAIL directed case%0d: valid=%b prod=%h required 1 %h", c, prod_valid, prod, exp_tab[c]);
      end
      drain();
      n_cmp++;
      if (busy !== 1'b0 || prod_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL drain case%0d: busy=%b valid=%b required 0 0", c, busy, prod_valid);
      end
    end
  endtask

  task automatic test_random_stall();
    logic [AW-1:0] exp;
    for (int it = 0; it < 20; it++) begin
      fill_random();
      exp = model(g, s);
      prod_ready = 0;
      send_all(3);
      // offered garbage while stalled must not be taken
      pp_valid = 1;
      pp_gen   = 9'($urandom);
      pp_sign  = 1'($urandom);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (prod_valid !== 1'b1 || prod !== exp || pp_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL stall it%0d k%0d: valid=%b prod=%h pp_ready=%b required 1 %h 0",
                   it, k, prod_valid, prod, pp_ready, exp);
        end
        @(negedge clk);
      end
      pp_valid = 0;
      drain();
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_release it%0d: busy=%b required 0", it, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH:0] ga [NPP];
    logic           sa [NPP];
    logic [AW-1:0]  exp_a, exp_b;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      ga = g; sa = s;
      exp_a = model(ga, sa);
      fill_random();
      exp_b = model(g, s);
      prod_ready = 1;
      for (int i = 0; i < NPP; i++) begin
        pp_valid = 1; pp_gen = ga[i]; pp_sign = sa[i];
        @(posedge clk); @(negedge clk);
      end
      n_cmp++;
      if (prod_valid !== 1'b1 || prod !== exp_a || pp_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_first it%0d: valid=%b prod=%h pp_ready=%b required 1 %h 1",
                 it, prod_valid, prod, pp_ready, exp_a);
      end
      for (int i = 0; i < NPP; i++) begin
        pp_gen = g[i]; pp_sign = s[i];
        @(posedge clk); @(negedge clk);
        if (i == 0) begin
          n_cmp++;
          if (prod_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_overlap it%0d: valid=%b busy=%b required 0 1", it, prod_valid, busy);
          end
        end
      end
      pp_valid = 0;
      n_cmp++;
      if (prod_valid !== 1'b1 || prod !== exp_b) begin
        n_bad++;
        $display("FAIL b2b_second it%0d: valid=%b prod=%h required 1 %h", it, prod_valid, prod, exp_b);
      end
      @(posedge clk); @(negedge clk);
      prod_ready = 0;
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_drain it%0d: busy=%b required 0", it, busy);
      end
    end
  endtask

  task automatic test_abort();
    logic [AW-1:0] exp;
    fill_random();
    prod_ready = 0;
    for (int i = 0; i < 3; i++) send(g[i], s[i], 0);
    abort = 1; pp_valid = 1; pp_gen = 9'h0FF; pp_sign = 1;
    n_cmp++;
    if (pp_ready !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_cycle: pp_ready=%b busy=%b required 1 1", pp_ready, busy);
    end
    @(posedge clk); @(negedge clk);
    abort = 0; pp_valid = 0;
    n_cmp++;
    if (busy !== 1'b0 || prod !== '0 || prod_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_flush: busy=%b prod=%h valid=%b required 0 00000 0", busy, prod, prod_valid);
    end
    fill_random();
    exp = model(g, s);
    send_all(1);
    n_cmp++;
    if (prod_valid !== 1'b1 || prod !== exp) begin
      n_bad++;
      $display("FAIL abort_recover: valid=%b prod=%h required 1 %h", prod_valid, prod, exp);
    end
    // abort in DONE beats a concurrent product handshake
    abort = 1; prod_ready = 1;
    n_cmp++;
    if (prod_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_done_valid: valid=%b required 1", prod_valid);
    end
    @(posedge clk); @(negedge clk);
    abort = 0; prod_ready = 0;
    n_cmp++;
    if (busy !== 1'b0 || prod !== '0) begin
      n_bad++;
      $display("FAIL abort_done: busy=%b prod=%h required 0 00000", busy, prod);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] exp;
    fill_random();
    prod_ready = 0;
    for (int i = 0; i < 2; i++) send(g[i], s[i], 0);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || prod !== '0 || pp_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b prod=%h pp_ready=%b required 0 00000 1", busy, prod, pp_ready);
    end
    @(negedge clk);
    rst_n = 1;
    fill_random();
    exp = model(g, s);
    send_all(2);
    n_cmp++;
    if (prod_valid !== 1'b1 || prod !== exp) begin
      n_bad++;
      $display("FAIL reset_recover: valid=%b prod=%h required 1 %h", prod_valid, prod, exp);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_stall();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
